top_mul_rr_arbiter: RTL and testbench



---
 rtl/top_mul_rr_arbiter_if.sv | 26 ++
 rtl/top_mul_rr_arbiter.sv | 112 +++++++++++
 tb/tb_top_mul_rr_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/top_mul_rr_arbiter_if.sv
// Handshake bundle between the requesters/consumer and the shared-multiplier arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding datapath.
interface top_mul_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_din0;
  logic [NREQ*32-1:0] req_din1;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic               out_ready;
  logic [IDW-1:0]     out_id;
  logic [63:0]        out_prod;
  logic [31:0]        op_count;

  modport slave (
    input  req_valid, req_din0, req_din1, out_ready,
    output req_ready, out_valid, out_id, out_prod, op_count
  );

  modport master (
    output req_valid, req_din0, req_din1, out_ready,
    input  req_ready, out_valid, out_id, out_prod, op_count
  );
endinterface

// File: rtl/top_mul_rr_arbiter.sv
// Round-robin arbiter in front of a single 32x32->64 unsigned multiplier.
// One operand pair is accepted per cycle; the product and owner ID sit in a
// one-deep result register that refills in the same cycle it drains.

// Single-cycle combinational unsigned multiplier.
module top_mul_32ns_32ns_64_1_1 (
  input  logic [31:0] din0,
  input  logic [31:0] din1,
  output logic [63:0] dout
);
  assign dout = {32'd0, din0} * {32'd0, din1};
endmodule

module top_mul_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  top_mul_rr_arbiter_if.slave     bus
);

  logic [IDW-1:0]  ptr_q,       ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [IDW-1:0]  out_id_q,    out_id_d;
  logic [63:0]     out_prod_q,  out_prod_d;
  logic [31:0]     op_count_q,  op_count_d;

  logic            slot_free;
  logic            found;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_oh;
  logic            xfer;
  logic            deliver;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [63:0]     mul_p;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign deliver   = out_valid_q && bus.out_ready;

  // Scan requesters starting at the pointer and pick the first one asserting valid.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // A grant is only issued out of reset and when the result slot can take a product.
  assign xfer   = found && slot_free && !ap_rst;
  assign gnt_oh = xfer ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.req_ready = gnt_oh;

  assign mul_a = bus.req_din0[32*gnt_idx +: 32];
  assign mul_b = bus.req_din1[32*gnt_idx +: 32];

  top_mul_32ns_32ns_64_1_1 u_mul (
    .din0 (mul_a),
    .din1 (mul_b),
    .dout (mul_p)
  );

  // Next state: refill on grant, drain when consumed, otherwise hold under backpressure.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_prod_d  = out_prod_q;
    op_count_d  = op_count_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt_idx;
      out_prod_d  = mul_p;
      ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end
    if (deliver) begin
      op_count_d = op_count_q + 32'd1;
    end
  end

  // State registers with synchronous reset; a pending result is dropped on reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_prod_q  <= '0;
      op_count_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_prod_q  <= out_prod_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_prod  = out_prod_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_top_mul_rr_arbiter.sv
// Directed bench for the round-robin shared-multiplier arbiter.
module tb_top_mul_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  top_mul_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bif ();

  top_mul_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bif.req_din0[32*i +: 32] = a;
    bif.req_din1[32*i +: 32] = b;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bif.req_valid = 4'hF;
    bif.req_din0  = '0;
    bif.req_din1  = '0;
    bif.out_ready = 1'b0;

    // Reset held two cycles with every requester asking.
    step();
    step();
    chk("rst_req_ready", 64'(bif.req_ready), 64'h0);
    chk("rst_out_valid", 64'(bif.out_valid), 64'h0);
    chk("rst_op_count",  64'(bif.op_count),  64'h0);
    chk("rst_out_prod",  bif.out_prod,       64'h0);
    chk("rst_out_id",    64'(bif.out_id),    64'h0);

    // Single request from requester 2 with maximal operands.
    rst           = 1'b0;
    bif.req_valid = 4'b0100;
    set_ops(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bif.out_ready = 1'b1;
    settle();
    chk("single_ready", 64'(bif.req_ready), 64'h4);
    step();
    bif.req_valid = 4'b0000;
    settle();
    chk("single_valid", 64'(bif.out_valid), 64'h1);
    chk("single_id",    64'(bif.out_id),    64'h2);
    chk("single_prod",  bif.out_prod,       64'hFFFF_FFFE_0000_0001);
    step();
    chk("single_drain", 64'(bif.out_valid), 64'h0);
    chk("single_count", 64'(bif.op_count),  64'h1);

    // Reset pulse returns the pointer to 0 and clears the counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_count", 64'(bif.op_count), 64'h0);

    // Round-robin with all four requesting continuously.
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'd10);
    bif.req_valid = 4'hF;
    settle();
    chk("rr_ready0", 64'(bif.req_ready), 64'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 4) bif.req_valid = 4'h0;
      settle();
      chk($sformatf("rr_valid%0d", k), 64'(bif.out_valid), 64'h1);
      chk($sformatf("rr_id%0d", k),    64'(bif.out_id),    64'(k % NREQ));
      chk($sformatf("rr_prod%0d", k),  bif.out_prod,       64'(10 * ((k % NREQ) + 1)));
      if (k < 4) chk($sformatf("rr_ready%0d", k + 1), 64'(bif.req_ready), 64'(1 << ((k + 1) % NREQ)));
    end
    step();
    chk("rr_drain", 64'(bif.out_valid), 64'h0);
    chk("rr_count", 64'(bif.op_count),  64'd5);

    // Backpressure: hold a product of 6 owned by requester 1.
    set_ops(1, 32'd2, 32'd3);
    set_ops(2, 32'd3, 32'd10);
    bif.req_valid = 4'b0010;
    step();
    chk("bp_id",   64'(bif.out_id), 64'h1);
    chk("bp_prod", bif.out_prod,    64'd6);
    bif.out_ready = 1'b0;
    bif.req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("bp_ready%0d", c), 64'(bif.req_ready), 64'h0);
      step();
      chk($sformatf("bp_valid%0d", c), 64'(bif.out_valid), 64'h1);
      chk($sformatf("bp_hid%0d", c),   64'(bif.out_id),    64'h1);
      chk($sformatf("bp_hprod%0d", c), bif.out_prod,       64'd6);
      chk($sformatf("bp_cnt%0d", c),   64'(bif.op_count),  64'd5);
    end
    bif.out_ready = 1'b1;
    settle();
    chk("bp_regrant", 64'(bif.req_ready), 64'h4);
    step();
    bif.req_valid = 4'h0;
    settle();
    chk("bp_new_id",   64'(bif.out_id),   64'h2);
    chk("bp_new_prod", bif.out_prod,      64'd30);
    chk("bp_new_cnt",  64'(bif.op_count), 64'd6);
    step();
    chk("bp_end_cnt", 64'(bif.op_count), 64'd7);

    // Pointer skip: pointer at 3, only requesters 0 and 1 asking.
    set_ops(0, 32'd7, 32'd5);
    set_ops(1, 32'd9, 32'd4);
    bif.req_valid = 4'b0011;
    settle();
    chk("skip_ready0", 64'(bif.req_ready), 64'h1);
    step();
    chk("skip_id0",    64'(bif.out_id),    64'h0);
    chk("skip_prod0",  bif.out_prod,       64'd35);
    chk("skip_ready1", 64'(bif.req_ready), 64'h2);
    step();
    bif.req_valid = 4'h0;
    settle();
    chk("skip_id1",   64'(bif.out_id), 64'h1);
    chk("skip_prod1", bif.out_prod,    64'd36);
    step();
    chk("skip_cnt", 64'(bif.op_count), 64'd9);

    // Counter wrap: preload all-ones, then deliver one result.
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    bif.req_valid = 4'b0001;
    step();
    bif.req_valid = 4'h0;
    chk("wrap_pre", 64'(bif.op_count), 64'hFFFF_FFFF);
    step();
    chk("wrap_post", 64'(bif.op_count), 64'h0);

    // Reset while a result is pending under backpressure.
    bif.req_valid = 4'b0100;
    step();
    bif.req_valid = 4'h0;
    bif.out_ready = 1'b0;
    chk("mid_pending", 64'(bif.out_valid), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", 64'(bif.out_valid), 64'h0);
    chk("mid_count", 64'(bif.op_count),  64'h0);
    bif.req_valid = 4'hF;
    settle();
    chk("mid_ptr", 64'(bif.req_ready), 64'h1);
    bif.req_valid = 4'h0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
